// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter/sequencer that shares one SPI shift engine between NREQ requesters.
// Optional WAIT-state timeout is compiled in when SPI_ARB_TIMEOUT_EN is defined.
module spi_req_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*16-1:0]   req_data,
  input  logic [NREQ-1:0]      req_len16,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 eng_start,
  output logic [15:0]          eng_data,
  output logic                 eng_len16,
  input  logic                 eng_busy,
  input  logic                 eng_done,
  input  logic [15:0]          eng_rdata
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   last_grant_reg, last_grant_next;
  logic [GW-1:0]   grant_idx;
  logic            grant_found;
  logic            accept;
  logic [15:0]     eng_data_reg, eng_data_next;
  logic            eng_len16_reg, eng_len16_next;
  logic [15:0]     rsp_data_reg, rsp_data_next;
  logic [15:0]     lane_data [NREQ];
  logic            tmo_hit;

  generate
    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_param
      $error("spi_req_arbiter: NREQ must be 2..8 and TIMEOUT_CYC 1..1023");
    end
  endgenerate

  // Reset also masks the combinational accept so no handshake escapes while ARESET is high.
  assign accept = (state_reg == IDLE) && grant_found && !ARESET;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane_data[gi] = req_data[16*gi +: 16];
      assign req_ready[gi] = accept && (grant_idx == GW'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == GW'(gi));
    end
  endgenerate

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = last_grant_reg;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant_reg) + off) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = GW'(idx);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);

  logic [9:0] tmo_cnt_reg, tmo_cnt_next;
  logic       rsp_err_reg, rsp_err_next;

  // Counter value is the index of the current WAIT cycle; the last allowed one forces RESP.
  assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    rsp_err_next = rsp_err_reg;
    if (state_reg == START && !eng_busy) begin
      tmo_cnt_next = '0;
    end else if (state_reg == WAIT) begin
      tmo_cnt_next = tmo_cnt_reg + 10'd1;
      if (eng_done) begin
        rsp_err_next = 1'b0;
      end else if (tmo_hit) begin
        rsp_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tmo_cnt_reg <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      rsp_err_reg <= rsp_err_next;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    eng_data_next   = eng_data_reg;
    eng_len16_next  = eng_len16_reg;
    rsp_data_next   = rsp_data_reg;
    eng_start       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          grant_next      = grant_idx;
          last_grant_next = grant_idx;
          eng_data_next   = lane_data[grant_idx];
          eng_len16_next  = req_len16[grant_idx];
          state_next      = START;
        end
      end
      START: begin
        if (!eng_busy) begin
          eng_start  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (eng_done) begin
          rsp_data_next = eng_rdata;
          state_next    = RESP;
        end else if (tmo_hit) begin
          rsp_data_next = '0;
          state_next    = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NREQ - 1);
      eng_data_reg   <= '0;
      eng_len16_reg  <= 1'b0;
      rsp_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      eng_data_reg   <= eng_data_next;
      eng_len16_reg  <= eng_len16_next;
      rsp_data_reg   <= rsp_data_next;
    end
  end

  assign eng_data  = eng_data_reg;
  assign eng_len16 = eng_len16_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: stimulus pushes expected grants, commands and
// responses; negedge monitors pop and compare whenever the DUT presents them.
module tb_spi_req_arbiter;
  localparam int NREQ = 4;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*16-1:0] req_data = '0;
  logic [NREQ-1:0]   req_len16 = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_data;
  logic              rsp_err;
  logic              eng_start;
  logic [15:0]       eng_data;
  logic              eng_len16;
  logic              eng_busy = 1'b0;
  logic              eng_done = 1'b0;
  logic [15:0]       eng_rdata = '0;

  spi_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(20)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_data(req_data), .req_len16(req_len16), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_data(eng_data), .eng_len16(eng_len16),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_rdata(eng_rdata)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_count = 0;
  int rsp_count = 0;

  int               exp_grant_q [$];
  logic [16:0]      exp_cmd_q   [$];   // {len16, data}
  logic [NREQ+16:0] exp_rsp_q   [$];   // {mask, err, data}

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (req_ready != '0) begin
        if (exp_grant_q.size() == 0) check("unexpected_ready", 32'(req_ready), 32'h0);
        else begin
          int g;
          g = exp_grant_q.pop_front();
          check("grant", 32'(req_ready), 32'(1) << g);
          $display("grant  cyc=%0d ready=%b", cyc, req_ready);
        end
      end
      if (eng_start) begin
        start_count++;
        if (exp_cmd_q.size() == 0) check("unexpected_start", 32'(eng_start), 32'h0);
        else begin
          logic [16:0] e;
          e = exp_cmd_q.pop_front();
          check("eng_data", 32'(eng_data), 32'(e[15:0]));
          check("eng_len16", 32'(eng_len16), 32'(e[16]));
          $display("start  cyc=%0d data=%h len16=%0d", cyc, eng_data, eng_len16);
        end
      end
      if (rsp_valid != '0) begin
        rsp_count++;
        if (exp_rsp_q.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'h0);
        else begin
          logic [NREQ+16:0] e;
          e = exp_rsp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(e[NREQ+16:17]));
          check("rsp_err", 32'(rsp_err), 32'(e[16]));
          check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
          $display("rsp    cyc=%0d valid=%b data=%h err=%0d", cyc, rsp_valid, rsp_data, rsp_err);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_data"},  32'(rsp_data),  32'h0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
    check({tag, "_eng_start"}, 32'(eng_start), 32'h0);
    check({tag, "_eng_data"},  32'(eng_data),  32'h0);
    check({tag, "_eng_len16"}, 32'(eng_len16), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    req_valid = '0;
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // which: 0 = req_ready, 1 = eng_start, 2 = rsp_valid; returns the cycle seen, -1 on timeout
  task automatic wait_sig(input int which, input int maxc, output int c);
    c = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge ACLK);
      if ((which == 0 && req_ready != '0) || (which == 1 && eng_start) ||
          (which == 2 && rsp_valid != '0)) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout which=%0d actual=none required=event within %0d cycles", which, maxc);
    end
  endtask

  task automatic engine_done_at(input int target, input logic [15:0] rd);
    while (cyc < target) begin
      @(posedge ACLK);
      #1;
    end
    eng_done  = 1'b1;
    eng_rdata = rd;
    @(posedge ACLK);
    #1;
    eng_done = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [15:0] d, input logic l);
    req_data[16*i +: 16] = d;
    req_len16[i] = l;
  endtask

  task automatic push_txn(input int g, input logic [15:0] d, input logic l,
                          input logic [15:0] rd, input logic err, input bit with_rsp);
    logic [NREQ-1:0] m;
    m = '0;
    m[g] = 1'b1;
    exp_grant_q.push_back(g);
    exp_cmd_q.push_back({l, d});
    if (with_rsp) exp_rsp_q.push_back({m, err, rd});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int c0, s, r, n0, rc;

    // Reset state
    #2;
    check_reset_outputs("reset");
    do_reset();

    // Single request on requester 1
    set_lane(1, 16'hA5C3, 1'b1);
    push_txn(1, 16'hA5C3, 1'b1, 16'h1234, 1'b0, 1);
    @(posedge ACLK); #1;
    req_valid = 4'b0010;
    wait_sig(0, 20, c0);
    @(posedge ACLK); #1;
    req_valid = '0;
    wait_sig(1, 20, s);
    check("start_latency", 32'(s - c0), 32'd1);
    engine_done_at(c0 + 40, 16'h1234);
    wait_sig(2, 20, r);
    check("rsp_latency", 32'(r - c0), 32'd41);

    // Round-robin: all four held high for 8 transactions
    do_reset();
    set_lane(0, 16'h1111, 1'b0);
    set_lane(1, 16'h2222, 1'b1);
    set_lane(2, 16'h3333, 1'b0);
    set_lane(3, 16'h4444, 1'b1);
    for (int n = 0; n < 8; n++) begin
      logic [15:0] d;
      d = 16'h1111 * 16'((n % 4) + 1);
      push_txn(n % 4, d, 1'((n % 4) & 1), 16'hD000 + 16'(n), 1'b0, 1);
    end
    @(posedge ACLK); #1;
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      wait_sig(1, 30, s);
      engine_done_at(s + 3, 16'hD000 + 16'(n));
      wait_sig(2, 30, r);
    end
    req_valid = '0;

    // Engine busy for 10 cycles after accept (last grant was 3, so 0 wins)
    n0 = start_count;
    eng_busy = 1'b1;
    push_txn(0, 16'h1111, 1'b0, 16'h5A5A, 1'b0, 1);
    @(posedge ACLK); #1;
    req_valid = 4'b0001;
    wait_sig(0, 20, c0);
    @(posedge ACLK); #1;
    req_valid = '0;
    while (cyc < c0 + 11) begin
      @(posedge ACLK); #1;
    end
    eng_busy = 1'b0;
    wait_sig(1, 20, s);
    check("busy_start_cycle", 32'(s - c0), 32'd11);
    #1;
    check("busy_start_count", 32'(start_count - n0), 32'd1);
    engine_done_at(s + 2, 16'h5A5A);
    wait_sig(2, 20, r);

    // Spurious done in IDLE
    @(posedge ACLK); #1;
    rc = rsp_count;
    eng_done = 1'b1;
    @(posedge ACLK); #1;
    eng_done = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("idle_done_rsp_count", 32'(rsp_count), 32'(rc));
    check("idle_done_eng_start", 32'(eng_start), 32'h0);

    // Spurious done in START
    eng_busy = 1'b1;
    push_txn(1, 16'h2222, 1'b1, 16'h0F0F, 1'b0, 1);
    req_valid = 4'b0010;
    wait_sig(0, 20, c0);
    @(posedge ACLK); #1;
    req_valid = '0;
    eng_done = 1'b1;
    @(posedge ACLK); #1;
    eng_done = 1'b0;
    @(posedge ACLK); #1;
    check("start_done_rsp_count", 32'(rsp_count), 32'(rc));
    check("start_done_eng_start", 32'(eng_start), 32'h0);
    eng_busy = 1'b0;
    wait_sig(1, 20, s);
    check("start_done_start_cycle", 32'(s - c0), 32'd3);
    engine_done_at(s + 2, 16'h0F0F);
    wait_sig(2, 20, r);

    // Reset mid-WAIT; the in-flight response is lost
    set_lane(2, 16'hBEEF, 1'b1);
    push_txn(2, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 0);
    @(posedge ACLK); #1;
    req_valid = 4'b0100;
    wait_sig(0, 20, c0);
    @(posedge ACLK); #1;
    req_valid = '0;
    wait_sig(1, 20, s);
    @(posedge ACLK); #3;
    ARESET = 1'b1;
    set_lane(0, 16'h0101, 1'b0);
    set_lane(3, 16'h0303, 1'b1);
    req_valid = 4'b1001;
    #1;
    check_reset_outputs("midwait");
    req_valid = '0;
    @(negedge ACLK);
    ARESET = 1'b0;
    // Pointer back to NREQ-1: requester 0 beats 3 (it would lose had last grant stayed 2)
    push_txn(0, 16'h0101, 1'b0, 16'hC0DE, 1'b0, 1);
    @(posedge ACLK); #1;
    req_valid = 4'b1001;
    wait_sig(0, 20, c0);
    @(posedge ACLK); #1;
    req_valid = '0;
    wait_sig(1, 20, s);
    engine_done_at(s + 4, 16'hC0DE);
    wait_sig(2, 20, r);
    push_txn(3, 16'h0303, 1'b1, 16'h3C3C, 1'b0, 1);
    @(posedge ACLK); #1;
    req_valid = 4'b1000;
    wait_sig(0, 20, c0);
    @(posedge ACLK); #1;
    req_valid = '0;
    wait_sig(1, 20, s);
    engine_done_at(s + 2, 16'h3C3C);
    wait_sig(2, 20, r);

    // Timeout: engine never returns done
`ifdef SPI_ARB_TIMEOUT_EN
    push_txn(0, 16'h0101, 1'b0, 16'h0000, 1'b1, 1);
`else
    push_txn(0, 16'h0101, 1'b0, 16'h0000, 1'b0, 0);
`endif
    @(posedge ACLK); #1;
    req_valid = 4'b0001;
    wait_sig(0, 20, c0);
    @(posedge ACLK); #1;
    req_valid = '0;
    wait_sig(1, 20, s);
`ifdef SPI_ARB_TIMEOUT_EN
    wait_sig(2, 40, r);
    check("timeout_cycle", 32'(r - s), 32'd21);
    #1;
    rc = rsp_count;
    engine_done_at(cyc + 1, 16'hFFFF);
    repeat (4) @(posedge ACLK);
    #1;
    check("late_done_rsp_count", 32'(rsp_count), 32'(rc));
`else
    #1;
    rc = rsp_count;
    repeat (60) @(posedge ACLK);
    #1;
    check("no_timeout_rsp_count", 32'(rsp_count), 32'(rc));
    do_reset();
`endif

    check("grant_q_empty", 32'(exp_grant_q.size()), 32'h0);
    check("cmd_q_empty",   32'(exp_cmd_q.size()),   32'h0);
    check("rsp_q_empty",   32'(exp_rsp_q.size()),   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
